// File: rtl/tiny_dnn_pkg.sv
// Shared types and constants for the accumulator-to-bfloat16 pack stage.
//   bf16_t        : 16-bit bfloat16 word
//   ACC_EXP_OFS   : offset between core exponent and bf16 biased exponent
//   BF16_INF_EXP  : all-ones bf16 exponent (infinity)
//   state_t       : row sequencer states
//   clz32()       : leading-zero count of a 32-bit word (32 for zero)
package tiny_dnn_pkg;

  typedef logic [15:0] bf16_t;

  localparam int          ACC_EXP_OFS  = 110;
  localparam logic [7:0]  BF16_INF_EXP = 8'hFF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd32;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(31 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/acc_bf16_pack_if.sv
// Stream bundle for acc_bf16_pack: accumulator input stream and bf16 output stream.
//   in_valid/in_ready/in_sign/in_expo/in_add : raw accumulator word from the FMA chain
//   m_valid/m_ready/m_data/m_last            : bf16 output row
// master = producer/consumer side (drives inputs, takes outputs); slave = the pack stage.
interface acc_bf16_pack_if;
  import tiny_dnn_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_expo;
  logic [31:0] in_add;
  logic        m_valid;
  logic        m_ready;
  bf16_t       m_data;
  logic        m_last;

  modport master (
    output in_valid, in_sign, in_expo, in_add, m_ready,
    input  in_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  in_valid, in_sign, in_expo, in_add, m_ready,
    output in_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/acc_bf16_round.sv
// Second conversion stage (combinational): normalizes a magnitude using its
// leading-zero count, rounds to nearest-even into 7 mantissa bits, adjusts the
// exponent, flushes underflow/zero to +0 and saturates overflow to infinity.
// Optional macro ACC_RELU_EN: negative results (including -inf) become 16'h0000.
//   sign   in  result sign
//   expo   in  signed core exponent
//   mag    in  unsigned magnitude
//   lz     in  leading zeros of mag
//   result out bfloat16 word
module acc_bf16_round
  import tiny_dnn_pkg::*;
(
  input  logic        sign,
  input  logic [9:0]  expo,
  input  logic [31:0] mag,
  input  logic [5:0]  lz,
  output bf16_t       result
);

  logic [31:0]        norm;
  logic               guard;
  logic               sticky;
  logic               rnd;
  logic [7:0]         mant_sum;
  logic signed [11:0] e_base;
  logic signed [11:0] e_fin;
  bf16_t              rounded;

  // NOTE: every output of this block is assigned unconditionally at the top of
  // each path, so no latch can be inferred.
  always_comb begin
    norm     = mag << lz;              // leading one lands on bit 31
    guard    = norm[23];
    sticky   = |norm[22:0];
    rnd      = guard & (sticky | norm[24]);
    mant_sum = {1'b0, norm[30:24]} + {7'd0, rnd};
    e_base   = {{2{expo[9]}}, expo} - 12'(ACC_EXP_OFS) - {6'd0, lz};
    e_fin    = e_base + {11'd0, mant_sum[7]};   // mantissa overflow bumps exponent

    if (mag == '0 || e_fin <= 12'sd0)
      rounded = '0;
    else if (e_fin >= 12'sd255)
      rounded = {sign, BF16_INF_EXP, 7'd0};
    else
      rounded = {sign, e_fin[7:0], mant_sum[6:0]};

    result = rounded;
`ifdef ACC_RELU_EN
    if (rounded[15]) result = '0;
`endif
  end

endmodule

// File: rtl/acc_bf16_pack.sv
// Pack stage after the FMA core chain: converts raw accumulator words to bf16
// (2-stage pipeline), buffers them in a credit-protected FIFO and emits one row
// of len words with m_last on the final word and a done pulse afterwards.
// Optional macro ACC_RELU_EN (applied in acc_bf16_round) clamps negatives to 0.
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   start  in  begin a row (IDLE only); len latched with it
//   len    in  words per row
//   busy   out sequencer not IDLE
//   done   out one-cycle pulse after the row's last handshake (or after len==0 start)
//   io     slave stream bundle (input words, output bf16 stream)
module acc_bf16_pack
  import tiny_dnn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  acc_bf16_pack_if.slave   io
);

  localparam int AW = $clog2(FIFO_DEPTH);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] acc_cnt;
  logic             zero_len_q;

  logic             s1_valid, s1_sign, s1_last;
  logic [9:0]       s1_expo;
  logic [31:0]      s1_mag;
  logic [5:0]       s1_lz;
  logic             s2_valid, s2_last;
  bf16_t            s2_data, s2_result;

  bf16_t            fifo_data [FIFO_DEPTH];
  logic             fifo_last [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [AW+1:0]    occupancy;

  logic             in_fire, out_fire, row_end;
  logic [31:0]      in_mag;

  // Credit: words already in the pipeline have reserved FIFO slots.
  assign occupancy   = {1'b0, count} + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
  assign io.in_ready = (state_q == RUN) && (acc_cnt < len_q) &&
                       (occupancy < (AW+2)'(FIFO_DEPTH));
  assign in_fire     = io.in_valid & io.in_ready;
  assign io.m_valid  = (count != '0);
  assign out_fire    = io.m_valid & io.m_ready;
  assign io.m_data   = io.m_valid ? fifo_data[rd_ptr] : '0;
  assign io.m_last   = io.m_valid ? fifo_last[rd_ptr] : 1'b0;
  assign row_end     = out_fire & io.m_last;
  assign in_mag      = io.in_add[31] ? (~io.in_add + 32'd1) : io.in_add;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE) || zero_len_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && len != '0) state_d = RUN;
      RUN:     if (row_end)            state_d = DONE;
      DONE:                            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      acc_cnt    <= '0;
      zero_len_q <= 1'b0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state_q    <= state_d;
      zero_len_q <= (state_q == IDLE) && start && (len == '0);
      if (state_q == IDLE && start) begin
        len_q   <= len;
        acc_cnt <= '0;
      end else if (in_fire) begin
        acc_cnt <= acc_cnt + LEN_W'(1);
      end
      s1_valid <= in_fire;
      s2_valid <= s1_valid;
      if (s2_valid) wr_ptr <= wr_ptr + AW'(1);
      if (out_fire) rd_ptr <= rd_ptr + AW'(1);
      unique case ({s2_valid, out_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: datapath and FIFO storage carry no reset; the valid bits and the
  // FIFO count gate them, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_sign <= io.in_sign ^ io.in_add[31];
      s1_mag  <= in_mag;
      s1_lz   <= clz32(in_mag);
      s1_expo <= io.in_expo;
      s1_last <= (acc_cnt == len_q - LEN_W'(1));
    end
    s2_data <= s2_result;
    s2_last <= s1_last;
    if (s2_valid) begin
      fifo_data[wr_ptr] <= s2_data;
      fifo_last[wr_ptr] <= s2_last;
    end
  end

  acc_bf16_round u_round (
    .sign   (s1_sign),
    .expo   (s1_expo),
    .mag    (s1_mag),
    .lz     (s1_lz),
    .result (s2_result)
  );

endmodule
